// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad-to-datapath controller for the calculator.
// Turns key strobes into operand-buffer command pulses and supervises the ALU.
//
// Parameters:
//   MAX_DIGITS  - BCD digits accepted per operand (extra digit keys dropped)
//   ALU_TIMEOUT - cycles allowed in CALC before error (1..255)
// Optional build macro:
//   CALC_CHAIN_EN - operator key in RESULT chains the result as operand 1
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   key_valid, key_code - one-cycle key strobe and code
//                         (0-9 digit, 10 add, 11 sub, 12 mul,
//                          13 equals, 14 clear, 15 negate)
//   alu_done, alu_err   - ALU completion strobe and its error qualifier
//   store_digit, digit  - pulse shifting digit into operand buffer
//   enter               - pulse committing operand 1
//   sign_toggle         - pulse negating current operand
//   clear               - pulse zeroing operand buffer
//   alu_start, alu_op   - ALU launch pulse, latched operation
//   result_ready        - pulse loading ALU result into buffer
//   busy, err           - high while in CALC / ERR
module calc_sequencer #(
    parameter int MAX_DIGITS  = 2,
    parameter int ALU_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       alu_done,
    input  logic       alu_err,
    output logic       store_digit,
    output logic [3:0] digit,
    output logic       enter,
    output logic       sign_toggle,
    output logic       clear,
    output logic       alu_start,
    output logic [1:0] alu_op,
    output logic       result_ready,
    output logic       busy,
    output logic       err
);

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0] DMAX = CW'(MAX_DIGITS);
    localparam logic [7:0] TMAX = 8'(ALU_TIMEOUT);

    typedef enum logic [2:0] {
        OP1    = 3'd0,
        OP2    = 3'd1,
        CALC   = 3'd2,
        RESULT = 3'd3,
        ERR    = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] dcnt;
    logic [7:0]    tcnt;
    logic          pend;
    logic [3:0]    pend_digit;

    logic       is_digit;
    logic       is_op;
    logic       is_eq;
    logic       is_clr;
    logic       is_neg;
    logic [1:0] key_op;

    assign is_digit = key_valid && (key_code <= 4'd9);
    assign is_op    = key_valid && (key_code >= 4'd10) && (key_code <= 4'd12);
    assign is_eq    = key_valid && (key_code == 4'd13);
    assign is_clr   = key_valid && (key_code == 4'd14);
    assign is_neg   = key_valid && (key_code == 4'd15);
    assign key_op   = 2'(key_code - 4'd10);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= OP1;
            dcnt         <= '0;
            tcnt         <= '0;
            pend         <= 1'b0;
            pend_digit   <= '0;
            store_digit  <= 1'b0;
            digit        <= '0;
            enter        <= 1'b0;
            sign_toggle  <= 1'b0;
            clear        <= 1'b0;
            alu_start    <= 1'b0;
            alu_op       <= '0;
            result_ready <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            store_digit  <= 1'b0;
            digit        <= '0;
            enter        <= 1'b0;
            sign_toggle  <= 1'b0;
            clear        <= 1'b0;
            alu_start    <= 1'b0;
            result_ready <= 1'b0;

            if (is_clr) begin
                // Clear beats alu_done and timeout on the same edge
                clear  <= 1'b1;
                dcnt   <= '0;
                tcnt   <= '0;
                alu_op <= '0;
                pend   <= 1'b0;
                busy   <= 1'b0;
                err    <= 1'b0;
                state  <= OP1;
            end else begin
                case (state)
                    OP1, OP2: begin
                        if (pend) begin
                            // Digit that started a new entry from RESULT;
                            // its cycle belongs to this pulse alone
                            store_digit <= 1'b1;
                            digit       <= pend_digit;
                            dcnt        <= CW'(1);
                            pend        <= 1'b0;
                        end else begin
                            unique case (1'b1)
                                is_digit: begin
                                    if (dcnt < DMAX) begin
                                        store_digit <= 1'b1;
                                        digit       <= key_code;
                                        dcnt        <= dcnt + CW'(1);
                                    end
                                end
                                is_neg: sign_toggle <= 1'b1;
                                is_op: begin
                                    if (state == OP1) begin
                                        alu_op <= key_op;
                                        enter  <= 1'b1;
                                        dcnt   <= '0;
                                        state  <= OP2;
                                    end else if (dcnt == '0) begin
                                        // Operator correction before operand 2
                                        alu_op <= key_op;
                                    end
                                end
                                is_eq: begin
                                    if (state == OP2 && dcnt != '0) begin
                                        alu_start <= 1'b1;
                                        tcnt      <= '0;
                                        busy      <= 1'b1;
                                        state     <= CALC;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    CALC: begin
                        tcnt <= tcnt + 8'd1;
                        if (alu_done) begin
                            busy <= 1'b0;
                            if (alu_err) begin
                                err   <= 1'b1;
                                state <= ERR;
                            end else begin
                                result_ready <= 1'b1;
                                state        <= RESULT;
                            end
                        end else if (tcnt + 8'd1 == TMAX) begin
                            busy  <= 1'b0;
                            err   <= 1'b1;
                            state <= ERR;
                        end
                    end
                    RESULT: begin
                        unique case (1'b1)
                            is_digit: begin
                                // Zero the displayed result first, then
                                // store the digit on the following cycle
                                clear      <= 1'b1;
                                pend       <= 1'b1;
                                pend_digit <= key_code;
                                dcnt       <= '0;
                                state      <= OP1;
                            end
                            is_neg: sign_toggle <= 1'b1;
`ifdef CALC_CHAIN_EN
                            is_op: begin
                                alu_op <= key_op;
                                enter  <= 1'b1;
                                dcnt   <= '0;
                                state  <= OP2;
                            end
`endif
                            default: ;
                        endcase
                    end
                    ERR: ;
                    default: begin
                        busy  <= 1'b0;
                        err   <= 1'b0;
                        state <= OP1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed self-checking bench for calc_sequencer.
// Ports: none (drives clock tb_clk and all DUT inputs).
module tb_calc_sequencer;

    localparam logic [5:0] SD = 6'b100000;
    localparam logic [5:0] EN = 6'b010000;
    localparam logic [5:0] SG = 6'b001000;
    localparam logic [5:0] CL = 6'b000100;
    localparam logic [5:0] AS = 6'b000010;
    localparam logic [5:0] RR = 6'b000001;
    localparam logic [5:0] NP = 6'b000000;

    localparam int S_OP1 = 0;
    localparam int S_OP2 = 1;
    localparam int S_CALC = 2;
    localparam int S_RES = 3;
    localparam int S_ERR = 4;

    logic       tb_clk;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_code;
    logic       alu_done;
    logic       alu_err;
    logic       store_digit;
    logic [3:0] digit;
    logic       enter;
    logic       sign_toggle;
    logic       clear;
    logic       alu_start;
    logic [1:0] alu_op;
    logic       result_ready;
    logic       busy;
    logic       err;

    int n_checks = 0;
    int n_fail = 0;

    logic [5:0] pulses;
    assign pulses = {store_digit, enter, sign_toggle,
                     clear, alu_start, result_ready};

    calc_sequencer #(.MAX_DIGITS(2), .ALU_TIMEOUT(16)) dut (
        .clk(tb_clk),
        .rst(rst),
        .key_valid(key_valid),
        .key_code(key_code),
        .alu_done(alu_done),
        .alu_err(alu_err),
        .store_digit(store_digit),
        .digit(digit),
        .enter(enter),
        .sign_toggle(sign_toggle),
        .clear(clear),
        .alu_start(alu_start),
        .alu_op(alu_op),
        .result_ready(result_ready),
        .busy(busy),
        .err(err)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Key sampled on the posedge inside; pulse visible on return
    task automatic press(input logic [3:0] code);
        @(negedge tb_clk);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge tb_clk);
        key_valid = 1'b0;
        key_code  = 4'd0;
    endtask

    function automatic int st();
        return int'(dut.state);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        key_valid = 1'b0;
        key_code = 4'd0;
        alu_done = 1'b0;
        alu_err = 1'b0;
        repeat (2) @(negedge tb_clk);
        check("rst_pulses", 32'(pulses), 32'(NP));
        check("rst_opbz", {alu_op, busy, err, digit}, 0);
        rst = 1'b0;
        @(negedge tb_clk);
        check("rst_state", st(), S_OP1);
        check("rst_out", {pulses, alu_op, busy, err, digit}, 0);

        // Digit limit
        press(4'd1);
        check("d1_p", 32'(pulses), 32'(SD));
        check("d1_v", 32'(digit), 1);
        press(4'd2);
        check("d2_p", 32'(pulses), 32'(SD));
        check("d2_v", 32'(digit), 2);
        press(4'd3);
        check("d3_drop", 32'(pulses), 32'(NP));
        check("d3_dig", 32'(digit), 0);
        check("d3_st", st(), S_OP1);
        press(4'd14);
        check("clr1", 32'(pulses), 32'(CL));

        // Operator handling and ALU done after 3 cycles
        press(4'd7);
        check("k7", 32'(pulses), 32'(SD));
        press(4'd11);
        check("sub_p", 32'(pulses), 32'(EN));
        check("sub_op", 32'(alu_op), 1);
        check("sub_st", st(), S_OP2);
        press(4'd11);
        check("sub2_p", 32'(pulses), 32'(NP));
        press(4'd10);
        check("add_p", 32'(pulses), 32'(NP));
        check("add_op", 32'(alu_op), 0);
        press(4'd5);
        check("k5", 32'(pulses), 32'(SD));
        check("k5_v", 32'(digit), 5);
        press(4'd13);
        check("eq_p", 32'(pulses), 32'(AS));
        for (int i = 0; i < 3; i++) begin
            check("busy3", 32'(busy), 1);
            if (i > 0) check("calc_p", 32'(pulses), 32'(NP));
            if (i == 2) alu_done = 1'b1;
            @(negedge tb_clk);
        end
        alu_done = 1'b0;
        check("res_p", 32'(pulses), 32'(RR));
        check("res_busy", 32'(busy), 0);
        check("res_st", st(), S_RES);
        check("res_op", 32'(alu_op), 0);

        // Operator in RESULT
        press(4'd10);
`ifdef CALC_CHAIN_EN
        check("chain_p", 32'(pulses), 32'(EN));
        check("chain_st", st(), S_OP2);
`else
        check("nochain_p", 32'(pulses), 32'(NP));
        check("nochain_st", st(), S_RES);
`endif
        press(4'd14);
        check("clr2", 32'(pulses), 32'(CL));

        // Back to RESULT, then negate and digit restart
        press(4'd3);
        press(4'd12);
        check("mul_op", 32'(alu_op), 2);
        press(4'd4);
        press(4'd13);
        alu_done = 1'b1;
        @(negedge tb_clk);
        alu_done = 1'b0;
        check("res2_p", 32'(pulses), 32'(RR));
        press(4'd15);
        check("res_neg", 32'(pulses), 32'(SG));
        press(4'd4);
        check("rd_clr", 32'(pulses), 32'(CL));
        check("rd_st", st(), S_OP1);
        @(negedge tb_clk);
        check("rd_sd", 32'(pulses), 32'(SD));
        check("rd_v", 32'(digit), 4);
        press(4'd5);
        check("rd_cnt2", 32'(pulses), 32'(SD));
        press(4'd6);
        check("rd_cnt3", 32'(pulses), 32'(NP));

        // Timeout into ERR
        press(4'd14);
        press(4'd9);
        press(4'd12);
        press(4'd2);
        press(4'd13);
        check("to_as", 32'(pulses), 32'(AS));
        repeat (15) @(negedge tb_clk);
        check("to_15_err", 32'(err), 0);
        check("to_15_busy", 32'(busy), 1);
        @(negedge tb_clk);
        check("to_16_err", 32'(err), 1);
        check("to_16_busy", 32'(busy), 0);
        press(4'd5);
        check("err_k5", 32'(pulses), 32'(NP));
        press(4'd13);
        check("err_k13", 32'(pulses), 32'(NP));
        alu_done = 1'b1;
        @(negedge tb_clk);
        alu_done = 1'b0;
        check("err_done", 32'(pulses), 32'(NP));
        check("err_st", st(), S_ERR);
        press(4'd14);
        check("err_clr", 32'(pulses), 32'(CL));
        check("err_clr_e", 32'(err), 0);
        check("err_clr_st", st(), S_OP1);

        // alu_err
        press(4'd1);
        press(4'd10);
        press(4'd2);
        press(4'd13);
        alu_done = 1'b1;
        alu_err = 1'b1;
        @(negedge tb_clk);
        alu_done = 1'b0;
        alu_err = 1'b0;
        check("aerr_p", 32'(pulses), 32'(NP));
        check("aerr_e", 32'(err), 1);
        check("aerr_st", st(), S_ERR);
        press(4'd14);

        // Clear on the same edge as alu_done
        press(4'd1);
        press(4'd10);
        press(4'd2);
        press(4'd13);
        key_valid = 1'b1;
        key_code = 4'd14;
        alu_done = 1'b1;
        @(negedge tb_clk);
        key_valid = 1'b0;
        key_code = 4'd0;
        alu_done = 1'b0;
        check("cd_p", 32'(pulses), 32'(CL));
        check("cd_st", st(), S_OP1);
        check("cd_busy", 32'(busy), 0);

        // alu_done on the final timeout edge wins
        press(4'd1);
        press(4'd10);
        press(4'd2);
        press(4'd13);
        repeat (15) @(negedge tb_clk);
        alu_done = 1'b1;
        @(negedge tb_clk);
        alu_done = 1'b0;
        check("edge_p", 32'(pulses), 32'(RR));
        check("edge_err", 32'(err), 0);
        press(4'd14);

        // OP1 negate/equals, OP2 operator with digits, stray alu_done
        press(4'd15);
        check("op1_neg", 32'(pulses), 32'(SG));
        press(4'd13);
        check("op1_eq", 32'(pulses), 32'(NP));
        check("op1_eq_st", st(), S_OP1);
        press(4'd10);
        press(4'd13);
        check("op2_eq0", 32'(pulses), 32'(NP));
        press(4'd3);
        press(4'd11);
        check("op2_opd", 32'(pulses), 32'(NP));
        check("op2_opd_op", 32'(alu_op), 0);
        alu_done = 1'b1;
        @(negedge tb_clk);
        alu_done = 1'b0;
        check("stray_done", 32'(pulses), 32'(NP));
        check("stray_st", st(), S_OP2);

        // Reset mid-CALC
        press(4'd13);
        check("rc_busy", 32'(busy), 1);
        #2 rst = 1'b1;
        #1;
        check("rc_out", {pulses, alu_op, busy, err, digit}, 0);
        #4 rst = 1'b0;
        @(negedge tb_clk);
        check("rc_rel", {pulses, alu_op, busy, err, digit}, 0);
        check("rc_st", st(), S_OP1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Central keypad-to-datapath controller for the calculator.
- Turns one-cycle key strobes into the command pulses that sequence the operand buffer (store_digit, enter, result_ready, clear, sign toggle).
- Launches the ALU and supervises its completion with a timeout.
- Sits between the keypad decoder and the operand-buffer/ALU pair; owns the calculator's entry state machine.

Parameters:
- MAX_DIGITS, 2, maximum BCD digits accepted per operand; further digit keys are dropped.
- ALU_TIMEOUT, 16, cycles allowed in CALC before declaring an error; legal range 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- key_valid  in  1  one-cycle key strobe
- key_code  in  4  0-9 digit; 10 add; 11 sub; 12 mul; 13 equals; 14 clear; 15 negate
- alu_done  in  1  ALU completion strobe
- alu_err  in  1  qualifies alu_done: overflow/invalid
- store_digit  out  1  pulse: shift digit into operand buffer
- digit  out  4  BCD digit accompanying store_digit, else 0
- enter  out  1  pulse: commit operand 1
- sign_toggle  out  1  pulse: negate current operand
- clear  out  1  pulse: zero operand buffer
- alu_start  out  1  pulse: begin operation
- alu_op  out  2  latched operation: 0 add, 1 sub, 2 mul
- result_ready  out  1  pulse: load ALU result into buffer
- busy  out  1  high while in CALC
- err  out  1  high while in ERR

Behaviour:
- Reset values:
  - State OP1; all pulses, digit, and alu_op are 0.
  - Digit count and timeout count are 0.
  - busy=0, err=0.
- Timing:
  - All outputs are registered.
  - A key sampled on edge N produces its pulse in the cycle after edge N, lasting exactly one cycle.
  - At most one command pulse is active per cycle, except clear, which may coincide with nothing else.
- Keys are ignored unless key_valid=1. Codes not legal in the current state are silently dropped.
- Clear (14), any state: clear pulse; digit count 0; alu_op 0; timeout count 0; go to OP1. Clear takes priority over alu_done and over timeout in the same cycle.
- OP1:
  - Digit with count<MAX_DIGITS: store_digit pulse, digit=key, count+1.
  - Digit with count==MAX_DIGITS: dropped.
  - Negate: sign_toggle pulse.
  - Operator (10-12): latch alu_op, enter pulse, count=0, go to OP2.
  - Equals: dropped.
- OP2:
  - Digits and negate behave as in OP1.
  - Operator with count==0: overwrites alu_op, no pulse.
  - Operator with count>0: dropped.
  - Equals with count==0: dropped.
  - Equals with count>0: alu_start pulse, timeout count 0, go to CALC.
- CALC (busy=1):
  - All keys except clear are dropped.
  - alu_done & !alu_err: result_ready pulse, go to RESULT.
  - alu_done & alu_err: go to ERR.
  - Timeout count increments every cycle. On reaching ALU_TIMEOUT with no alu_done: go to ERR.
  - alu_done on the same edge as the final count: alu_done wins.
- RESULT:
  - Digit: clear pulse; hold the digit as pending; go to OP1. Next cycle: store_digit pulse with the pending digit, count=1.
  - Negate: sign_toggle pulse.
  - Operator: dropped (see optional feature).
  - Equals: dropped.
- ERR (err=1): only clear exits. alu_done is ignored.
- alu_done outside CALC is ignored.
- Reset asserted mid-operation, e.g. in CALC, returns immediately to reset values. No pulse is emitted on release.

Optional Feature:
- Macro: CALC_CHAIN_EN.
- Defined: an operator key in RESULT latches alu_op, pulses enter (committing the displayed result as operand 1), sets count=0, and goes to OP2. This allows chained operations such as 3+4=+5=.
- Undefined: an operator key in RESULT is dropped; only a digit, negate, or clear leaves RESULT.

Test Plan:
- Reset, then key 1, key 2, key 3 -> two store_digit pulses with digit=1, then digit=2; third digit produces no pulse; state OP1.
- Keys 7, 11, 11 with count 0, then 10, 5, 13; ALU returns alu_done after 3 cycles -> enter pulse once; alu_op ends at 0; alu_start one cycle after equals; busy 3 cycles; result_ready pulse; state RESULT.
- Keys 9, 12, 2, 13; alu_done never arrives, ALU_TIMEOUT=16 -> err=1 exactly 16 cycles after entering CALC; keys 5 and 13 are dropped; key 14 -> clear pulse, err=0, state OP1.
- In CALC, alu_done=1 with alu_err=1 -> ERR, no result_ready. Separately, key 14 on the same edge as alu_done -> clear pulse and state OP1, no result_ready.
- From RESULT, key 4 -> clear pulse, then store_digit with digit=4 the next cycle. Key 10 in RESULT: with CALC_CHAIN_EN, enter pulse and state OP2; without it, no pulse and state RESULT.
- Assert rst for half a cycle while in CALC with busy=1 -> all outputs 0 immediately; state OP1 after release.
